// File: rtl/latch_load_sequencer.sv
// latch_load_sequencer
//
// Upstream driver for a transparent latch bank. Collects a serial MSB-first
// bitstream over a valid/ready handshake, presents the assembled word on din,
// then drives a timed enable window:
//   din stable SETUP_CYC cycles -> enable high OPEN_CYC cycles -> din held
//   HOLD_CYC cycles -> one-cycle done pulse.
//
// Optional feature (compile-time macro LATCH_LOAD_PARITY_EN): each word is
// followed by one even-parity bit. On mismatch the word is dropped, err pulses
// for one cycle and no enable window is issued. Without the macro err is 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   sin        in   serial data bit, MSB first
//   sin_valid  in   sin carries a valid bit
//   sin_ready  out  block accepts a bit (combinational from state)
//   din        out  [WIDTH] word to latch bank data inputs (registered)
//   enable     out  latch bank enable (registered)
//   busy       out  first accepted bit until the word is finished (registered)
//   done       out  one-cycle pulse at end of HOLD (registered)
//   err        out  one-cycle parity-error pulse (registered)

module latch_load_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned OPEN_CYC  = 4,
  parameter int unsigned HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] din,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef LATCH_LOAD_PARITY_EN
  localparam int unsigned NBits = WIDTH + 1;
`else
  localparam int unsigned NBits = WIDTH;
`endif

  localparam int unsigned MaxSo  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int unsigned MaxCyc = (MaxSo > HOLD_CYC) ? MaxSo : HOLD_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned BitW   = $clog2(NBits + 1);

  // Counter is loaded with phase length minus one and the phase ends on zero.
  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] OpenLd  = CntW'(OPEN_CYC - 1);
  localparam logic [CntW-1:0] HoldLd  = CntW'(HOLD_CYC - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(NBits - 1);

  typedef enum logic [2:0] {StIdle, StShift, StSetup, StOpen, StHold} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             xfer;
  logic [WIDTH-1:0] shifted;

  assign sin_ready = (state_q == StIdle) || (state_q == StShift);
  assign xfer      = sin_valid & sin_ready;
  assign shifted   = {sreg_q[WIDTH-2:0], sin};

`ifndef LATCH_LOAD_PARITY_EN
  // The MSB of the shift register is shifted out without being needed here.
  logic unused_sreg_msb;
  assign unused_sreg_msb = sreg_q[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      din_q    <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      din_q    <= din_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    din_d    = din_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          sreg_d   = {{(WIDTH-1){1'b0}}, sin};
          bitcnt_d = BitW'(1);
          busy_d   = 1'b1;
          state_d  = StShift;
        end
      end

      StShift: begin
        if (xfer) begin
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == LastBit) begin
`ifdef LATCH_LOAD_PARITY_EN
            // Final bit is the parity bit; it is checked, not shifted in.
            if (sin == (^sreg_q)) begin
              din_d   = sreg_q;
              cnt_d   = SetupLd;
              state_d = StSetup;
            end else begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end
`else
            din_d   = shifted;
            cnt_d   = SetupLd;
            state_d = StSetup;
`endif
          end else begin
            sreg_d = shifted;
          end
        end
      end

      StSetup: begin
        if (cnt_q == '0) begin
          enable_d = 1'b1;
          cnt_d    = OpenLd;
          state_d  = StOpen;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StOpen: begin
        if (cnt_q == '0) begin
          enable_d = 1'b0;
          cnt_d    = HoldLd;
          state_d  = StHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StHold: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        enable_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  assign din    = din_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
